tone_frame_sequencer: RTL and testbench
=======================================

Name: tone_frame_sequencer

Overview:
- Sequences one DTMF analysis frame at a time: triggers the FFT, gates the tone-detector enable for exactly one frame of bins, and waits for the detector's done/tone result.
- Debounces results across frames (digit accepted only after HOLD_FRAMES identical consecutive frames, re-armed only after a silent frame) and buffers accepted digits in a small FIFO with a valid/ready output.
- Sits between the FFT front end, the tone detector and the control FSM that consumes keyed digits.

Parameters:
- BINS_PER_FRAME, 45, detector-enable cycles per frame (bin indices 0..44)
- HOLD_FRAMES, 2, consecutive identical non-zero tone frames required to accept a digit (>=1)
- DONE_TIMEOUT, 64, max cycles to wait for det_done after enable drops
- FIFO_DEPTH, 4, accepted-digit buffer depth (power of 2)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- run  in  1  level; while high, frames are issued back-to-back
- fft_start  out  1  one-cycle pulse requesting a new FFT frame
- bin_valid  in  1  FFT bin-stream valid; first high cycle = bin 0
- det_enable  out  1  tone-detector enable, high exactly BINS_PER_FRAME cycles per frame
- det_done  in  1  detector result-ready strobe
- det_tone  in  16  detector tone code; 16'h0000 = no tone
- digit  out  16  head-of-FIFO tone code
- digit_valid  out  1  FIFO non-empty
- digit_ready  in  1  consumer pops when digit_valid && digit_ready
- busy  out  1  high in any state except IDLE
- overflow  out  1  sticky; accepted digit dropped because FIFO full
- timeout_err  out  1  sticky; det_done not seen within DONE_TIMEOUT

Behaviour:
- Reset (reset_n low at a clock edge): state=IDLE; all outputs 0; FIFO emptied; hold counter, last-tone register and armed flag cleared (armed=1). Reset mid-frame aborts the frame with no further fft_start/det_enable.
- FSM: IDLE -> START when run=1. START: fft_start=1 for one cycle -> WAIT_BINS. WAIT_BINS: det_enable=bin_valid. On the first bin_valid=1 -> COLLECT, with bin count=1.
- COLLECT: det_enable=1 every cycle; bin counter increments. When count reaches BINS_PER_FRAME, det_enable drops on the next cycle -> WAIT_DONE. bin_valid is ignored after the first bin.
- WAIT_DONE: timeout counter runs. On det_done=1, latch det_tone -> EVAL. If DONE_TIMEOUT cycles elapse first, set timeout_err, treat the tone as 0 -> EVAL.
- EVAL (1 cycle):
  - tone==0: clear hold count, armed=1.
  - tone!=0 and tone==last: increment hold count, saturating at HOLD_FRAMES.
  - tone!=0 and tone!=last: hold count=1.
  - Accept condition: after the update, hold count==HOLD_FRAMES and armed=1. On accept, push tone into the FIFO and set armed=0.
  - last<=tone in all cases.
  - Next state: START if run=1, else IDLE.
- run falling mid-frame: the current frame completes through EVAL; no new START is issued.
- FIFO:
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push while full without a pop: digit dropped, overflow=1.
  - Pop while empty: ignored.
  - digit/digit_valid are registered; the pushed digit becomes visible the cycle after EVAL.
- Sticky flags clear only on reset.
- Frame latency: START to EVAL = 1 + bin wait + BINS_PER_FRAME + 1 + done wait cycles.

Optional Feature:
- Macro TONE_SEQ_STATS_EN.
- Defined: adds output frame_count[15:0] (frames completed, incremented in EVAL, saturating at 16'hFFFF) and output reject_count[7:0] (non-zero-tone frames not accepted because unarmed or still below HOLD_FRAMES, saturating at 8'hFF). Both are 0 on reset.
- Undefined: neither port nor its counters exists; all other behaviour is identical.

Test Plan:
- Reset/idle: run=0 for 20 cycles -> fft_start, det_enable, busy, digit_valid all 0; assert reset mid-COLLECT -> det_enable=0 next cycle, state IDLE.
- Single frame: run=1, bin_valid rises 5 cycles after fft_start, det_done at +3 cycles with tone 16'h0105 -> det_enable high exactly 45 cycles; no digit pushed (hold=1 < 2).
- Debounce: frames with tone 16'h0105, 16'h0105, 16'h0105, 0, 16'h0105, 16'h0105 -> exactly two digits 16'h0105 pushed, after frames 2 and 6.
- Timeout: det_done never asserted -> timeout_err=1 exactly 64 cycles after det_enable falls; frame treated as silence; the next frame still starts while run=1.
- FIFO full: digit_ready=0, five distinct accepted digits -> first four held in order, overflow=1; then digit_ready=1 -> 16'h0101..16'h0104 popped in order, digit_valid drops after the 4th pop.
- Run drop: deassert run during COLLECT -> frame finishes, EVAL occurs, no further fft_start, busy falls the cycle after EVAL.

Source files
------------

// File: rtl/tone_frame_sequencer.sv
// DTMF frame sequencer: FFT trigger, detector gating, debounce, digit FIFO.
// Optional statistics outputs are enabled with `define TONE_SEQ_STATS_EN.
module tone_frame_sequencer #(
    parameter int BINS_PER_FRAME = 45,
    parameter int HOLD_FRAMES    = 2,
    parameter int DONE_TIMEOUT   = 64,
    // power of two, at least 2
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    output logic        fft_start,
    input  logic        bin_valid,
    output logic        det_enable,
    input  logic        det_done,
    input  logic [15:0] det_tone,
    output logic [15:0] digit,
    output logic        digit_valid,
    input  logic        digit_ready,
    output logic        busy,
    output logic        overflow,
    output logic        timeout_err
`ifdef TONE_SEQ_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [7:0]  reject_count
`endif
);

    localparam int BW = $clog2(BINS_PER_FRAME + 1);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BINS,
        COLLECT,
        WAIT_DONE,
        EVAL
    } state_t;

    state_t state;
    state_t state_next;

    logic [BW-1:0] bin_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit;
    logic [15:0]   tone_q;

    logic [HW-1:0] hold;
    logic [HW-1:0] hold_next;
    logic [15:0]   last;
    logic          armed;
    logic          armed_next;
    logic          accept;
    logic          push;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          do_push;

    assign timeout_hit = (state == WAIT_DONE) && !det_done
                       && (tmo_cnt == TW'(DONE_TIMEOUT - 1));

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (run) state_next = START;
            START:     state_next = WAIT_BINS;
            WAIT_BINS: begin
                if (bin_valid)
                    state_next = (BINS_PER_FRAME == 1) ? WAIT_DONE : COLLECT;
            end
            COLLECT: begin
                if (bin_cnt == BW'(BINS_PER_FRAME - 1))
                    state_next = WAIT_DONE;
            end
            WAIT_DONE: if (det_done || timeout_hit) state_next = EVAL;
            EVAL:      state_next = run ? START : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Moore/Mealy outputs of the frame FSM
    always_comb begin
        fft_start  = 1'b0;
        det_enable = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE:      busy = 1'b0;
            START:     fft_start = 1'b1;
            WAIT_BINS: det_enable = bin_valid;
            COLLECT:   det_enable = 1'b1;
            default:   ;
        endcase
    end

    // Bin counter and detector-done timeout counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bin_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == WAIT_BINS && bin_valid) bin_cnt <= BW'(1);
            else if (state == COLLECT)           bin_cnt <= bin_cnt + BW'(1);
            if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + TW'(1);
            else                    tmo_cnt <= '0;
        end
    end

    // Latch detector result; a missing result counts as silence
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tone_q      <= '0;
            timeout_err <= 1'b0;
        end else if (state == WAIT_DONE) begin
            if (det_done) begin
                tone_q <= det_tone;
            end else if (timeout_hit) begin
                tone_q      <= '0;
                timeout_err <= 1'b1;
            end
        end
    end

    // Debounce decision for the frame being evaluated
    always_comb begin
        hold_next  = hold;
        armed_next = armed;
        accept     = 1'b0;
        if (tone_q == 16'h0000) begin
            hold_next  = '0;
            armed_next = 1'b1;
        end else if (tone_q == last) begin
            if (hold != HW'(HOLD_FRAMES)) hold_next = hold + HW'(1);
        end else begin
            hold_next = HW'(1);
        end
        if (tone_q != 16'h0000 && hold_next == HW'(HOLD_FRAMES) && armed) begin
            accept     = 1'b1;
            armed_next = 1'b0;
        end
    end

    assign push = (state == EVAL) && accept;

    // Debounce state, updated once per frame
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hold  <= '0;
            last  <= '0;
            armed <= 1'b1;
        end else if (state == EVAL) begin
            hold  <= hold_next;
            armed <= armed_next;
            last  <= tone_q;
        end
    end

    assign full        = (count == CW'(FIFO_DEPTH));
    assign digit_valid = (count != '0);
    assign pop         = digit_valid && digit_ready;
    assign do_push     = push && (!full || pop);
    assign digit       = digit_valid ? mem[rd_ptr] : 16'h0000;

    // Digit storage
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= tone_q;
    end

    // FIFO pointers, occupancy and drop flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (!do_push && pop) count <= count - CW'(1);
            if (push && !do_push) overflow <= 1'b1;
        end
    end

`ifdef TONE_SEQ_STATS_EN
    // Frame and rejected-tone statistics, saturating
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            frame_count  <= '0;
            reject_count <= '0;
        end else if (state == EVAL) begin
            if (frame_count != 16'hFFFF)
                frame_count <= frame_count + 16'd1;
            if (tone_q != 16'h0000 && !accept && reject_count != 8'hFF)
                reject_count <= reject_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tone_frame_sequencer.sv
// Testbench for tone_frame_sequencer: frame table, corner sequences,
// randomized frames against a frame-level debounce/FIFO model.
module tb_tone_frame_sequencer;

    localparam int BINS  = 45;
    localparam int HOLD  = 2;
    localparam int TMO   = 64;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        bin_valid = 1'b0;
    logic        det_done = 1'b0;
    logic [15:0] det_tone = 16'h0000;
    logic        digit_ready = 1'b0;
    logic        fft_start;
    logic        det_enable;
    logic [15:0] digit;
    logic        digit_valid;
    logic        busy;
    logic        overflow;
    logic        timeout_err;
`ifdef TONE_SEQ_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  reject_count;
`endif

    tone_frame_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .run         (run),
        .fft_start   (fft_start),
        .bin_valid   (bin_valid),
        .det_enable  (det_enable),
        .det_done    (det_done),
        .det_tone    (det_tone),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err)
`ifdef TONE_SEQ_STATS_EN
        ,
        .frame_count (frame_count),
        .reject_count(reject_count)
`endif
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model state (frame level)
    logic [15:0] mq[$];
    logic [15:0] popped_q[$];
    int          pop_cnt = 0;
    bit          chk_en = 0;
    int          ready_mode = 0;
    bit          exp_ovf = 0;
    bit          exp_tmo = 0;
    int          m_streak = 0;
    logic [15:0] m_last = 16'h0000;
    bit          m_armed = 1;
    int          m_frames = 0;
    int          m_rejects = 0;
    int          en_cnt = 0;

    task automatic model_clear();
        mq.delete();
        popped_q.delete();
        exp_ovf   = 0;
        exp_tmo   = 0;
        m_streak  = 0;
        m_last    = 16'h0000;
        m_armed   = 1;
        m_frames  = 0;
        m_rejects = 0;
    endtask

    // Digit accepted when the current run of identical tones is long
    // enough and no digit was taken since the last silent frame.
    task automatic model_eval(input logic [15:0] t, output bit acc);
        acc = 0;
        if (t == 16'h0000) begin
            m_streak = 0;
            m_armed  = 1;
        end else begin
            m_streak = (t == m_last) ? m_streak + 1 : 1;
            if (m_armed && m_streak >= HOLD) begin
                acc     = 1;
                m_armed = 0;
            end
        end
        m_last = t;
        m_frames++;
        if (t != 16'h0000 && !acc) m_rejects++;
    endtask

    // Count detector-enable cycles, sampled mid low phase
    always @(negedge clock) begin
        #3;
        if (det_enable === 1'b1) en_cnt++;
    end

    // Consumer: drives ready, checks FIFO head against the model
    always @(negedge clock) begin
        case (ready_mode)
            0:       digit_ready = 1'b0;
            1:       digit_ready = 1'b1;
            default: digit_ready = ($urandom_range(0, 2) != 0);
        endcase
        if (chk_en) begin
            check("digit_valid", 32'(digit_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) check("digit", 32'(digit), 32'(mq[0]));
            if (digit_valid && digit_ready && mq.size() != 0) begin
                popped_q.push_back(mq[0]);
                void'(mq.pop_front());
                pop_cnt++;
            end
        end
    end

    task automatic do_reset();
        chk_en    = 0;
        reset_n   = 1'b0;
        run       = 1'b0;
        bin_valid = 1'b0;
        det_done  = 1'b0;
        det_tone  = 16'h0000;
        repeat (2) @(negedge clock);
        model_clear();
        reset_n = 1'b1;
        chk_en  = 1;
    endtask

    // Drive one frame. drop_at: 0 = drop run at fft_start,
    // k>0 = drop run at the k-th collect cycle, <0 = keep run.
    task automatic frame(input int bd, input int dd, input logic [15:0] tone,
                         input bit give_done, input int drop_at,
                         output bit acc);
        int          k;
        bit          was;
        logic [15:0] t_eff;
        k = 0;
        while (fft_start !== 1'b1 && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("fft_start_seen", 32'(fft_start), 32'd1);
        en_cnt = 0;
        if (drop_at == 0) run = 1'b0;
        @(negedge clock);
        check("fft_pulse", 32'(fft_start), 32'd0);
        repeat (bd - 1) @(negedge clock);
        bin_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clock);
            k++;
            if (k == drop_at) run = 1'b0;
            bin_valid = (det_enable === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end while (det_enable === 1'b1 && k < 200);
        check("enable_cycles", 32'(en_cnt), 32'(BINS));
        det_tone = 16'($urandom);
        if (give_done) begin
            repeat (dd) @(negedge clock);
            det_done = 1'b1;
            det_tone = tone;
            @(negedge clock);
            det_done = 1'b0;
            det_tone = 16'($urandom);
            t_eff    = tone;
        end else begin
            was = timeout_err;
            repeat (TMO - 1) @(negedge clock);
            if (!was) check("tmo_early", 32'(timeout_err), 32'd0);
            @(negedge clock);
            if (!was) check("tmo_set", 32'(timeout_err), 32'd1);
            exp_tmo = 1;
            t_eff   = 16'h0000;
        end
        check("busy_eval", 32'(busy), 32'd1);
        #1;
        model_eval(t_eff, acc);
        if (acc) begin
            if (mq.size() < DEPTH) mq.push_back(t_eff);
            else                   exp_ovf = 1;
        end
    endtask

    typedef struct {
        int          bd;
        int          dd;
        logic [15:0] tone;
        bit          give_done;
        bit          exp_acc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        bit          acc;
        int          p0;
        int          k;
        logic [15:0] t;
        logic [15:0] tones[4];
        logic [15:0] exp_d;

        tbl[0] = '{5, 3, 16'h0105, 1'b1, 1'b0};
        tbl[1] = '{2, 0, 16'h0105, 1'b1, 1'b1};
        tbl[2] = '{1, 7, 16'h0105, 1'b1, 1'b0};
        tbl[3] = '{3, 2, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{4, 1, 16'h0105, 1'b1, 1'b0};
        tbl[5] = '{1, 5, 16'h0105, 1'b1, 1'b1};
        tbl[6] = '{2, 0, 16'h0105, 1'b0, 1'b0};
        tbl[7] = '{3, 4, 16'h0203, 1'b1, 1'b0};
        tbl[8] = '{1, 1, 16'h0203, 1'b1, 1'b1};

        // Reset and idle
        do_reset();
        check("reset_outs",
              32'({fft_start, det_enable, busy, digit_valid,
                   overflow, timeout_err, digit}), 32'd0);
        repeat (20) begin
            @(negedge clock);
            check("idle_outs",
                  32'({fft_start, det_enable, busy, digit_valid}), 32'd0);
        end

        // Frame table: single frame, debounce, timeout
        ready_mode = 1;
        run = 1'b1;
        foreach (tbl[i]) begin
            p0 = pop_cnt;
            frame(tbl[i].bd, tbl[i].dd, tbl[i].tone, tbl[i].give_done,
                  (i == 8) ? 0 : -1, acc);
            @(negedge clock);
            #2;
            check("row_accept", 32'(pop_cnt - p0), 32'(tbl[i].exp_acc));
        end
        check("table_busy_end", 32'(busy), 32'd0);
        check("table_tmo", 32'(timeout_err), 32'(exp_tmo));
        check("table_ovf", 32'(overflow), 32'(exp_ovf));

        // run falls mid-COLLECT
        run = 1'b1;
        frame(2, 3, 16'h0309, 1'b1, 10, acc);
        @(negedge clock);
        check("busy_after_eval", 32'(busy), 32'd0);
        repeat (10) begin
            @(negedge clock);
            check("no_restart", 32'(fft_start), 32'd0);
        end

        // Reset in the middle of COLLECT
        run = 1'b1;
        k = 0;
        while (fft_start !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        bin_valid = 1'b1;
        repeat (10) @(negedge clock);
        check("collect_en", 32'(det_enable), 32'd1);
        chk_en    = 0;
        reset_n   = 1'b0;
        run       = 1'b0;
        bin_valid = 1'b0;
        @(negedge clock);
        check("rst_mid_en", 32'({det_enable, busy}), 32'd0);
        model_clear();
        reset_n = 1'b1;
        chk_en  = 1;
        repeat (5) begin
            @(negedge clock);
            check("rst_mid_quiet", 32'({fft_start, det_enable}), 32'd0);
        end

        // FIFO full with consumer stalled
        do_reset();
        ready_mode = 0;
        run = 1'b1;
        for (int d = 1; d <= 5; d++) begin
            frame(3, 2, 16'(16'h0100 + d), 1'b1, -1, acc);
            frame(1, 0, 16'(16'h0100 + d), 1'b1, -1, acc);
            frame(2, 1, 16'h0000, 1'b1, (d == 5) ? 0 : -1, acc);
        end
        @(negedge clock);
        check("full_ovf", 32'(overflow), 32'd1);
        check("full_valid", 32'(digit_valid), 32'd1);
        check("full_head", 32'(digit), 32'h0101);
        ready_mode = 1;
        repeat (8) @(negedge clock);
        check("drain_count", 32'(popped_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            exp_d = 16'(16'h0101 + i);
            if (i < popped_q.size())
                check("drain_order", 32'(popped_q[i]), 32'(exp_d));
        end
        check("drain_empty", 32'(digit_valid), 32'd0);

        // Randomized frames
        do_reset();
        ready_mode = 2;
        tones[0] = 16'h0000;
        tones[1] = 16'h0105;
        tones[2] = 16'h0203;
        tones[3] = 16'h0309;
        t = 16'h0105;
        run = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 99) >= 60) t = tones[$urandom_range(0, 3)];
            frame($urandom_range(1, 6), $urandom_range(0, 12), t,
                  $urandom_range(0, 19) != 0, (i == 59) ? 0 : -1, acc);
        end
        ready_mode = 1;
        repeat (10) @(negedge clock);
        check("rand_ovf", 32'(overflow), 32'(exp_ovf));
        check("rand_tmo", 32'(timeout_err), 32'(exp_tmo));
        check("rand_idle", 32'(busy), 32'd0);
`ifdef TONE_SEQ_STATS_EN
        check("frame_count", 32'(frame_count), 32'(m_frames));
        check("reject_count", 32'(reject_count), 32'(m_rejects));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
